vga_scanout: RTL and testbench
==============================

# vga_scanout

Read side of the pixel framebuffer: generates 640x480@60 VGA raster timing from `system_clock` and walks `framebuffer_read_pointer` in raster order through the same 640*480-entry linear address space the pixel receiver fills. It samples the 12-bit RAM output on each pixel tick and drives registered RGB444, sync and display-enable signals to the DAC/connector. It sits beside `pixel_memory`, driving that block's read-pointer input and consuming its `read_data` output.

## Interface

Parameters:
- `CLOCK_DIVIDER`, 2: `system_clock` cycles per pixel tick; must be ≥2.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in ticks.
- `H_SYNC`, 96: horizontal sync width, in ticks.
- `H_BACK`, 48: horizontal back porch, in ticks.
- `V_VISIBLE`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.

Ports (one clock; reset is asynchronous and active-low):
- `system_clock` input 1: sole clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `read_data` input 12: RAM output, {R[11:8], G[7:4], B[3:0]}; valid one cycle after the pointer changes.
- `framebuffer_read_pointer` output 22: linear pixel address to the RAM.
- `red`, `green`, `blue` output 4 each: pixel colour.
- `hsync` output 1: active low.
- `vsync` output 1: active low.
- `display_enable` output 1: high while RGB carries a visible pixel.
- `frame_start` output 1: one-cycle pulse at each frame wrap.

## Operation

- **Divider.** Counts 0..CLOCK_DIVIDER-1. The tick is the cycle where count == CLOCK_DIVIDER-1; the counter then wraps to 0.
- **Raster counters.** h counts 0..H_TOTAL-1, with H_TOTAL = 800. v counts 0..V_TOTAL-1, with V_TOTAL = 525.
  - On each tick, h increments.
  - At h == 799, h wraps to 0 and v increments.
  - At (799, 524), both wrap to (0, 0).
- **Visible region.** Visible = h < H_VISIBLE && v < V_VISIBLE.
- **Sync regions.** Hsync is active for H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751. Vsync is active for 490 ≤ v ≤ 491.
- **Pointer invariant.** Whenever (h, v) is visible, `framebuffer_read_pointer` equals v*640 + h.
- **Pointer update on a tick:**
  - Current position visible and not (639, 479): pointer <= pointer + 1.
  - Current position (639, 479): pointer <= 0, matching the writer's wrap at 307199.
  - Current position not visible: pointer holds. It therefore sits on the next line's first address during blanking.
- **Output stage on each tick** (all outputs registered):
  - RGB <= visible ? read_data fields : 0.
  - `display_enable` <= visible.
  - `hsync` <= ~hsync_region.
  - `vsync` <= ~vsync_region.
- **Frame marker.** `frame_start` is high for exactly one cycle, the cycle following the tick at which (h, v) wraps from (799, 524) to (0, 0).
- **Width rules.**
  - h is 10 bits; v is 10 bits.
  - Pointer arithmetic is 22 bits unsigned; the maximum value used is 307199.
- **Reset values.**
  - Divider, h, v and pointer are 0.
  - RGB is 0.
  - `display_enable` = 0, `frame_start` = 0.
  - `hsync` = 1 and `vsync` = 1 (inactive).
- **Reset mid-operation.** Asserting reset mid-frame restarts the raster at (0, 0) with pointer 0. No partial-line recovery.

## Timing

- Pixel rate is `system_clock` / CLOCK_DIVIDER.
- Between ticks the pointer is stable for CLOCK_DIVIDER-1 ≥ 1 cycles, so `read_data` is settled at the tick.
- Output latency is one tick: RGB, sync and `display_enable` describe the (h, v) held before the advancing tick.
- All outputs change only on the cycle after a tick. `frame_start` is the only one that returns low after one cycle.
- Line = 800 ticks; frame = 420000 ticks, which is 840000 cycles at CLOCK_DIVIDER = 2.

## Test plan

- **Reset:** hold `reset_n` = 0 with `read_data` = 0xFFF -> all outputs at their reset values. After release, the first tick at 2 cycles registers RGB = 0xF/0xF/0xF and `display_enable` = 1, with the pointer moving to 1.
- **Line 0 pointer walk:** ramp `read_data` = pointer[11:0] -> `framebuffer_read_pointer` steps 0..639, one step per 2 cycles. RGB echoes each value one tick later. The pointer holds 640 through h = 640..799.
- **Hsync:** measure `hsync` -> low for 96 ticks (192 cycles) starting 656 ticks after the line's first tick; period 1600 cycles; `display_enable` high 640 ticks per line.
- **Vsync and frame wrap:** run a full frame -> `vsync` low for 2 lines (3200 cycles). The pointer goes 307199 -> 0 at (639, 479). `frame_start` pulses once, with pulses 840000 cycles apart.
- **Blanking mask:** `read_data` = 0xABC constant -> RGB = 0 and `display_enable` = 0 on every blanking tick; RGB = A/B/C on visible ticks.
- **Reset mid-line:** assert `reset_n` low at h = 300, v = 100 for 3 cycles -> outputs return to reset values immediately (asynchronously). After release, pointer restarts at 0 and the next `frame_start` occurs 840000 cycles later.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing generator that walks the framebuffer read pointer and drives registered RGB444/sync
module vga_scanout #(
    parameter int CLOCK_DIVIDER = 2,
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33
) (
    input  logic        system_clock,
    input  logic        reset_n,
    input  logic [11:0] read_data,
    output logic [21:0] framebuffer_read_pointer,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        display_enable,
    output logic        frame_start
);
    localparam int DIV_W = $clog2(CLOCK_DIVIDER);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [21:0]      ptr_q, ptr_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             de_q, de_d, hs_n_q, hs_n_d, vs_n_q, vs_n_d, fs_q, fs_d;
    logic             tick, h_end, v_end, visible, last_pixel, hsync_region, vsync_region;

    // Position decode for the current (h, v) and the pixel tick
    always_comb begin
        tick         = div_q == DIV_LAST;
        h_end        = h_q == H_LAST;
        v_end        = v_q == V_LAST;
        visible      = h_q < H_VIS && v_q < V_VIS;
        last_pixel   = h_q == H_VIS - 10'd1 && v_q == V_VIS - 10'd1;
        hsync_region = h_q >= H_SYNC_BEG && h_q < H_SYNC_END;
        vsync_region = v_q >= V_SYNC_BEG && v_q < V_SYNC_END;
    end

    // Divider, raster counters and read pointer; the pointer only advances on visible ticks so it parks on the next line's first address during blanking
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = tick ? (h_end ? '0 : h_q + 10'd1) : h_q;
        v_d   = tick && h_end ? (v_end ? '0 : v_q + 10'd1) : v_q;
        ptr_d = tick && visible ? (last_pixel ? '0 : ptr_q + 22'd1) : ptr_q;
    end

    // Output stage describes the position held before the advancing tick
    always_comb begin
        rgb_d  = tick ? (visible ? read_data : 12'h000) : rgb_q;
        de_d   = tick ? visible : de_q;
        hs_n_d = tick ? ~hsync_region : hs_n_q;
        vs_n_d = tick ? ~vsync_region : vs_n_q;
        fs_d   = tick && h_end && v_end;
    end

    // State registers; sync outputs reset inactive (high)
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            ptr_q  <= '0;
            rgb_q  <= '0;
            de_q   <= 1'b0;
            hs_n_q <= 1'b1;
            vs_n_q <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            ptr_q  <= ptr_d;
            rgb_q  <= rgb_d;
            de_q   <= de_d;
            hs_n_q <= hs_n_d;
            vs_n_q <= vs_n_d;
            fs_q   <= fs_d;
        end
    end

    assign framebuffer_read_pointer = ptr_q;
    assign red                      = rgb_q[11:8];
    assign green                    = rgb_q[7:4];
    assign blue                     = rgb_q[3:0];
    assign display_enable           = de_q;
    assign hsync                    = hs_n_q;
    assign vsync                    = vs_n_q;
    assign frame_start              = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout on a scaled-down raster
module tb_vga_scanout;
    localparam int DIV = 2;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CYC = HT * VT * DIV;
    localparam logic [15:0] RST_OUT = 16'h0006;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] rd = 12'hFFF;
    logic [21:0] ptr;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, de, fs;
    logic [15:0] out_v;

    int n_checks = 0, n_err = 0;
    int mdiv, mh, mv, mptr, mode, cyc, ref_cyc, hs_lo, vs_lo, de_hi;
    bit have_ref;
    logic [15:0] exq[$];
    logic [15:0] cur;

    vga_scanout #(
        .CLOCK_DIVIDER(DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .system_clock(clk),
        .reset_n(rst_n),
        .read_data(rd),
        .framebuffer_read_pointer(ptr),
        .red(red),
        .green(green),
        .blue(blue),
        .hsync(hsync),
        .vsync(vsync),
        .display_enable(de),
        .frame_start(fs)
    );

    assign out_v = {red, green, blue, de, hsync, vsync, fs};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mdiv = 0;
        mh = 0;
        mv = 0;
        mptr = 0;
        exq.delete();
        cur = RST_OUT;
        ref_cyc = cyc;
        have_ref = 1'b1;
        hs_lo = 0;
        vs_lo = 0;
        de_hi = 0;
    endtask

    task automatic drive_rd();
        rd = mode == 0 ? 12'(mptr) : mode == 1 ? 12'hABC : 12'hFFF;
    endtask

    task automatic step();
        bit tick, vis, hsr, vsr, wrap;
        tick = mdiv == DIV - 1;
        if (tick) begin
            vis  = mh < HV && mv < VV;
            hsr  = mh >= HV + HF && mh < HV + HF + HS;
            vsr  = mv >= VV + VF && mv < VV + VF + VS;
            wrap = mh == HT - 1 && mv == VT - 1;
            exq.push_back({vis ? rd : 12'h000, vis, ~hsr, ~vsr, wrap});
            if (vis) mptr = (mh == HV - 1 && mv == VV - 1) ? 0 : mptr + 1;
            if (mh == HT - 1) begin
                mh = 0;
                mv = mv == VT - 1 ? 0 : mv + 1;
            end else mh = mh + 1;
        end
        mdiv = tick ? 0 : mdiv + 1;
        @(posedge clk);
        #1;
        cyc++;
        if (tick) begin
            if (exq.size() == 0) check("queue_empty", 1, 0);
            else cur = exq.pop_front();
        end else cur[0] = 1'b0;
        check("out", 32'(out_v), 32'(cur));
        check("ptr", 32'(ptr), 32'(mptr));
        if (fs) begin
            if (have_ref) begin
                check("fs_gap", 32'(cyc - ref_cyc), 32'(FRAME_CYC));
                check("hsync_low_cycles", 32'(hs_lo), 32'(VT * HS * DIV));
                check("vsync_low_cycles", 32'(vs_lo), 32'(VS * HT * DIV));
                check("de_high_cycles", 32'(de_hi), 32'(VV * HV * DIV));
            end
            ref_cyc = cyc;
            have_ref = 1'b1;
            hs_lo = 0;
            vs_lo = 0;
            de_hi = 0;
        end
        hs_lo += int'(!hsync);
        vs_lo += int'(!vsync);
        de_hi += int'(de);
        drive_rd();
    endtask

    initial begin
        cyc = 0;
        mode = 2;
        model_reset();
        have_ref = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'(out_v), 32'(RST_OUT));
        check("rst_ptr", 32'(ptr), 32'd0);
        #3 rst_n = 1'b1;
        model_reset();
        drive_rd();
        repeat (4) step();
        mode = 0;
        drive_rd();
        repeat (2 * FRAME_CYC) step();
        mode = 1;
        drive_rd();
        repeat (2 * FRAME_CYC) step();
        mode = 0;
        drive_rd();
        for (int i = 0; i < FRAME_CYC && !(mh == 5 && mv == 2); i++) step();
        check("mid_reset_position", 32'(mh * 100 + mv), 32'd502);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out_v), 32'(RST_OUT));
        check("async_rst_ptr", 32'(ptr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("held_rst_out", 32'(out_v), 32'(RST_OUT));
        #2 rst_n = 1'b1;
        model_reset();
        drive_rd();
        repeat (2 * FRAME_CYC + 4) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
